// File: rtl/risc_ctrl_pkg.sv
// Shared types for the RISC_16 control sequencer.
// FSM states, opcode constants and opcode-class decode.
package risc_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_HALT,
      CLS_NOP
   } opclass_t;

   localparam logic [3:0] OP_ALU_MAX = 4'h7;
   localparam logic [3:0] OP_LOAD    = 4'h8;
   localparam logic [3:0] OP_STORE   = 4'h9;
   localparam logic [3:0] OP_BRANCH  = 4'hA;
   localparam logic [3:0] OP_HALT    = 4'hF;

   // ext flags nonzero opcode bits above the 4-bit core field
   function automatic opclass_t op_class(
      input logic [3:0] op,
      input logic       ext
   );
      opclass_t c;
      c = CLS_NOP;
      if (!ext) begin
         unique case (1'b1)
            (op <= OP_ALU_MAX): c = CLS_ALU;
            (op == OP_LOAD):    c = CLS_LOAD;
            (op == OP_STORE):   c = CLS_STORE;
            (op == OP_BRANCH):  c = CLS_BRANCH;
            (op == OP_HALT):    c = CLS_HALT;
            default:            c = CLS_NOP;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/risc_ctrl_seq_if.sv
// Sequencer bus: memory handshake, IR/ALU inputs,
// phase strobes and status outputs.
interface risc_ctrl_seq_if #(
   parameter int ADDR_W = 6,
   parameter int OPC_W  = 4,
   parameter int CNT_W  = 16
);
   logic [OPC_W-1:0]  opcode;
   logic              mem_ack;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] instruction_addr;
   logic              pc_enable;
   logic              ir_enable;
   logic              mem_enable;
   logic              reg_enable;
   logic              mem_req;
   logic              halted;
   logic              fault;
   logic [CNT_W-1:0]  retired;

   modport master (
      input  opcode, mem_ack, branch_taken, branch_target,
      output instruction_addr, pc_enable, ir_enable,
      output mem_enable, reg_enable, mem_req,
      output halted, fault, retired
   );

   modport slave (
      output opcode, mem_ack, branch_taken, branch_target,
      input  instruction_addr, pc_enable, ir_enable,
      input  mem_enable, reg_enable, mem_req,
      input  halted, fault, retired
   );
endinterface

// File: rtl/risc_mem_wait_timer.sv
// Counts cycles a memory request waits for ack and
// flags a timeout on the last permitted wait cycle.
module risc_mem_wait_timer #(
   parameter int WAIT_MAX = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   input  logic ack,
   output logic timeout
);
   localparam int CW = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count only while waiting; any ack or idle clears.
   always_comb begin
      cnt_d   = '0;
      timeout = 1'b0;
      if (busy && !ack) begin
         cnt_d   = cnt_q + 1'b1;
         timeout = (cnt_q == CW'(WAIT_MAX - 1));
      end
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle control sequencer: PC, phase strobes,
// memory handshake, branch redirect, halt, retire count.
module risc_ctrl_seq
   import risc_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int OPC_W    = 4,
   parameter int RESET_PC = 0,
   parameter int WAIT_MAX = 7,
   parameter int CNT_W    = 16
) (
   input logic           clk,
   input logic           rst,
   risc_ctrl_seq_if.master bus
);
   localparam int XW = (OPC_W > 4) ? OPC_W : 5;

   state_t            state_q, state_d;
   opclass_t          cls_q, cls_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic              fault_q, fault_d;
   logic              retire;
   logic              wait_busy;
   logic              timeout;
   logic [XW-1:0]     opc_x;

   logic pc_en, ir_en, mem_en, reg_en, req, hlt;

   assign opc_x     = XW'(bus.opcode);
   assign wait_busy = (state_q == FETCH) || (state_q == MEM);

   risc_mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .busy    (wait_busy),
      .ack     (bus.mem_ack),
      .timeout (timeout)
   );

   // Next-state, PC/retire update and phase strobes.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      retire  = 1'b0;
      pc_en   = 1'b0;
      ir_en   = 1'b0;
      mem_en  = 1'b0;
      reg_en  = 1'b0;
      req     = 1'b0;
      hlt     = 1'b0;
      unique case (state_q)
         FETCH: begin
            req = 1'b1;
            if (bus.mem_ack) begin
               ir_en   = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               fault_d = 1'b1;
               state_d = HALT;
            end
         end
         DECODE: begin
            pc_en = 1'b1;
            pc_d  = pc_q + 1'b1;
            cls_d = op_class(opc_x[3:0], |opc_x[XW-1:4]);
            unique case (cls_d)
               CLS_ALU, CLS_BRANCH: state_d = EXEC;
               CLS_LOAD, CLS_STORE: state_d = MEM;
               CLS_HALT: begin
                  retire  = 1'b1;
                  state_d = HALT;
               end
               default: begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         EXEC: begin
            if (cls_q == CLS_BRANCH) begin
               retire  = 1'b1;
               state_d = FETCH;
               if (bus.branch_taken) begin
                  pc_en = 1'b1;
                  pc_d  = bus.branch_target;
               end
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            mem_en = 1'b1;
            req    = 1'b1;
            if (bus.mem_ack) begin
               if (cls_q == CLS_LOAD) begin
                  state_d = WB;
               end else begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end
            end else if (timeout) begin
               fault_d = 1'b1;
               state_d = HALT;
            end
         end
         WB: begin
            reg_en  = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
         end
         HALT: hlt = 1'b1;
         default: state_d = FETCH;
      endcase
      ret_d = ret_q;
      if (retire && (ret_q != {CNT_W{1'b1}})) begin
         ret_d = ret_q + 1'b1;
      end
   end

   // Outputs read idle while reset is held.
   always_comb begin
      bus.pc_enable  = pc_en  && !rst;
      bus.ir_enable  = ir_en  && !rst;
      bus.mem_enable = mem_en && !rst;
      bus.reg_enable = reg_en && !rst;
      bus.mem_req    = req    && !rst;
      bus.halted     = hlt    && !rst;
   end

   assign bus.instruction_addr = pc_q;
   assign bus.retired          = ret_q;
   assign bus.fault            = fault_q;

   // State, PC, class, counter and fault registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         cls_q   <= CLS_NOP;
         pc_q    <= ADDR_W'(RESET_PC);
         ret_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         pc_q    <= pc_d;
         ret_q   <= ret_d;
         fault_q <= fault_d;
      end
   end
endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Directed bench for risc_ctrl_seq.
// Second instance with a 3-bit counter covers saturation.
module tb_risc_ctrl_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   risc_ctrl_seq_if #(.ADDR_W(6), .OPC_W(4), .CNT_W(16)) u_if ();
   risc_ctrl_seq_if #(.ADDR_W(6), .OPC_W(4), .CNT_W(3))  u_sif ();

   risc_ctrl_seq #(
      .ADDR_W(6), .OPC_W(4), .RESET_PC(0),
      .WAIT_MAX(7), .CNT_W(16)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   risc_ctrl_seq #(
      .ADDR_W(6), .OPC_W(4), .RESET_PC(0),
      .WAIT_MAX(7), .CNT_W(3)
   ) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (u_sif)
   );

   assign u_sif.opcode        = 4'hB;
   assign u_sif.mem_ack       = 1'b1;
   assign u_sif.branch_taken  = 1'b0;
   assign u_sif.branch_target = 6'h00;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // {pc_enable, ir_enable, mem_enable, reg_enable, mem_req}
   function automatic logic [31:0] vec();
      return {27'd0, u_if.pc_enable, u_if.ir_enable,
              u_if.mem_enable, u_if.reg_enable, u_if.mem_req};
   endfunction

   // One cycle: drive at negedge, outputs settle for checks.
   task automatic step(input logic r, input logic ack,
                       input logic [3:0] opc, input logic bt,
                       input logic [5:0] tgt);
      @(negedge clk);
      rst                  = r;
      u_if.mem_ack         = ack;
      u_if.opcode          = opc;
      u_if.branch_taken    = bt;
      u_if.branch_target   = tgt;
      #1;
   endtask

   initial begin
      u_if.mem_ack       = 1'b0;
      u_if.opcode        = 4'h0;
      u_if.branch_taken  = 1'b0;
      u_if.branch_target = 6'h00;

      // reset state
      step(1, 1, 4'h3, 0, 0);
      chk("rst_strobes", vec(), 32'h0);
      chk("rst_addr", u_if.instruction_addr, 32'h0);
      chk("rst_retired", u_if.retired, 32'h0);
      chk("rst_fault", u_if.fault, 32'h0);
      chk("rst_halted", u_if.halted, 32'h0);

      // ALU 0x3, zero-wait
      step(0, 1, 4'h3, 0, 0);
      chk("alu_c1", vec(), 32'b01001);
      step(0, 0, 4'h3, 0, 0);
      chk("alu_c2", vec(), 32'b10000);
      chk("alu_c2_addr", u_if.instruction_addr, 32'h0);
      step(0, 0, 4'h0, 0, 0);
      chk("alu_c3", vec(), 32'b00000);
      chk("alu_c3_addr", u_if.instruction_addr, 32'h1);
      step(0, 0, 4'h0, 0, 0);
      chk("alu_c4", vec(), 32'b00010);
      chk("alu_c4_ret", u_if.retired, 32'h0);

      // LOAD aborted by reset mid-MEM wait
      step(0, 1, 4'h8, 0, 0);
      chk("alu_retired", u_if.retired, 32'h1);
      step(0, 0, 4'h8, 0, 0);
      step(0, 0, 4'h0, 0, 0);
      chk("mid_mem", vec(), 32'b00101);
      step(0, 0, 4'h0, 0, 0);
      step(1, 0, 4'h0, 0, 0);
      chk("mid_rst_strobes", vec(), 32'h0);
      step(0, 0, 4'h0, 0, 0);
      chk("mid_rst_addr", u_if.instruction_addr, 32'h0);
      chk("mid_rst_ret", u_if.retired, 32'h0);
      chk("mid_rst_req", vec(), 32'b00001);

      // LOAD with ack on the 4th MEM cycle
      step(0, 1, 4'h8, 0, 0);
      chk("ld_fetch", vec(), 32'b01001);
      step(0, 0, 4'h8, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, (i == 3), 4'h0, 0, 0);
         chk("ld_mem", vec(), 32'b00101);
      end
      step(0, 0, 4'h0, 0, 0);
      chk("ld_wb", vec(), 32'b00010);

      // NOPs advance PC to 5
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 4'hB, 0, 0);
         if (i == 0) begin
            chk("ld_retired", u_if.retired, 32'h1);
            chk("ld_addr", u_if.instruction_addr, 32'h1);
         end
         step(0, 0, 4'hB, 0, 0);
      end

      // taken branch at PC 5 to 0x3E
      step(0, 1, 4'hA, 0, 0);
      chk("br_pc5", u_if.instruction_addr, 32'h5);
      chk("nop_retired", u_if.retired, 32'h5);
      step(0, 0, 4'hA, 0, 0);
      step(0, 0, 4'h0, 1, 6'h3E);
      chk("br_t_exec", vec(), 32'b10000);
      chk("br_t_pc6", u_if.instruction_addr, 32'h6);

      // not-taken branch at 0x3E
      step(0, 1, 4'hA, 0, 0);
      chk("br_t_tgt", u_if.instruction_addr, 32'h3E);
      step(0, 0, 4'hA, 0, 0);
      step(0, 0, 4'h0, 0, 6'h15);
      chk("br_nt_exec", vec(), 32'b00000);

      // NOP at PC 63 wraps
      step(0, 1, 4'hB, 0, 0);
      chk("br_nt_pc", u_if.instruction_addr, 32'h3F);
      chk("br_retired", u_if.retired, 32'h7);
      step(0, 0, 4'hB, 0, 0);

      // HALT opcode
      step(0, 1, 4'hF, 0, 0);
      chk("wrap_pc", u_if.instruction_addr, 32'h0);
      step(0, 0, 4'hF, 0, 0);
      chk("hlt_dec", vec(), 32'b10000);
      for (int i = 0; i < 50; i++) begin
         step(0, 1, 4'h0, 1, 6'h2A);
         chk("hlt_quiet", {vec(), 31'd0} | u_if.halted, 32'h1);
      end
      chk("hlt_retired", u_if.retired, 32'h9);
      chk("hlt_addr", u_if.instruction_addr, 32'h1);
      chk("sat_retired", u_sif.retired, 32'h7);

      // ack on the last permitted wait cycle
      step(1, 0, 4'h0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 4'h3, 0, 0);
      step(0, 1, 4'h3, 0, 0);
      chk("late_ack_ir", vec(), 32'b01001);
      step(0, 0, 4'h3, 0, 0);
      chk("late_ack_dec", vec(), 32'b10000);
      chk("late_ack_flt", u_if.fault, 32'h0);

      // no ack: timeout after 7 wait cycles
      step(1, 0, 4'h0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 4'h3, 0, 0);
      chk("to_c7_fault", u_if.fault, 32'h0);
      chk("to_c7_req", vec(), 32'b00001);
      step(0, 0, 4'h3, 0, 0);
      chk("to_fault", u_if.fault, 32'h1);
      chk("to_halted", u_if.halted, 32'h1);
      chk("to_retired", u_if.retired, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 4'h0, 0, 0);
         chk("to_quiet", vec(), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/risc_ctrl_seq.md
Name: risc_ctrl_seq

Overview:
Parametrised multi-cycle control sequencer for the RISC_16 core family. It owns the program counter and generates the per-phase enables (pc_enable, ir_enable, mem_enable, reg_enable) that the current top-level hard-sequences. It adds a memory req/ack handshake with a bounded wait timeout, taken-branch redirect, a HALT state and a retired-instruction counter. It sits between instruction/data memory and the datapath inside the top level.

Parameters:
ADDR_W, 6, PC / instruction address width
OPC_W, 4, opcode field width
RESET_PC, 0, PC value loaded on reset
WAIT_MAX, 7, max cycles to wait for mem_ack before timeout fault
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
opcode  in  OPC_W  opcode field from IR; sampled in DECODE
mem_ack  in  1  memory completes the current request this cycle
branch_taken  in  1  branch condition from ALU flags; sampled in EXEC
branch_target  in  ADDR_W  branch destination; sampled in EXEC
instruction_addr  out  ADDR_W  registered PC
pc_enable  out  1  PC update strobe
ir_enable  out  1  IR load strobe
mem_enable  out  1  data-memory access phase
reg_enable  out  1  register-file write strobe
mem_req  out  1  memory request, held until mem_ack
halted  out  1  core stopped (HALT state)
fault  out  1  sticky, set by memory timeout
retired  out  CNT_W  completed-instruction count, saturating

Behaviour:
- Reset applies when rst=1 at a clk edge: state=FETCH, instruction_addr=RESET_PC, retired=0, fault=0, wait counter=0. All strobes, mem_req and halted read 0 while rst=1. rst has priority in every state, including mid-handshake.
- Strobes and mem_req are combinational decodes of state and mem_ack. instruction_addr, retired and fault are registered.
- FETCH: mem_req=1. On mem_ack: ir_enable=1 for that cycle, then go to DECODE.
- DECODE (1 cycle): pc_enable=1. instruction_addr <= instruction_addr+1, wrapping modulo 2^ADDR_W. Next state by opcode class:
  - ALU (0x0-0x7) -> EXEC
  - LOAD (0x8) or STORE (0x9) -> MEM
  - BRANCH (0xA) -> EXEC
  - HALT (0xF) -> HALT
  - 0xB-0xE: NOP, retire -> FETCH
- EXEC (1 cycle):
  - ALU -> WB.
  - BRANCH with branch_taken=1: pc_enable=1, instruction_addr <= branch_target; retire -> FETCH.
  - BRANCH with branch_taken=0: PC unchanged; retire -> FETCH.
- MEM: mem_enable=1 and mem_req=1 until mem_ack. On ack, LOAD -> WB; STORE retires -> FETCH.
- WB (1 cycle): reg_enable=1, retire -> FETCH.
- HALT: halted=1, all strobes and mem_req=0. Exits only on rst. Entering HALT from the HALT opcode counts as one retire.
- Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle without mem_ack. If it reaches WAIT_MAX with no ack, set fault=1 and go to HALT with no retire. mem_ack on the same cycle the counter reaches WAIT_MAX counts as success.
- Retire means retired <= retired+1 on the completing edge; it saturates at 2^CNT_W-1.
- The opcode package is indexed by a decoded class, so OPC_W>4 only adds NOP space.
- Minimum latencies with zero-wait memory (ack in first request cycle):
  - ALU 4 cycles
  - LOAD 4 cycles
  - STORE 3 cycles
  - BRANCH 3 cycles
  - NOP 2 cycles

Decomposition:
- Package risc_ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, HALT
  - opcode constants: OP_LOAD, OP_STORE, OP_BRANCH, OP_HALT, ALU range bound
  - opcode-class enum plus a class-decode function
- One sub-module, risc_mem_wait_timer: the wait counter plus timeout compare, parametrised by WAIT_MAX.
- The FSM and PC stay in risc_ctrl_seq.

Test Plan:
- Reset mid-MEM wait (rst=1 one cycle) -> next cycle state FETCH, instruction_addr=0, retired=0, mem_req=1.
- ALU opcode 0x3, mem_ack in first cycle -> ir_enable, pc_enable, (EXEC), reg_enable on cycles 1, 2, 4. instruction_addr 0->1. retired=1 after 4 cycles.
- LOAD with mem_ack delayed 3 cycles in MEM -> mem_enable high for exactly 4 cycles, then reg_enable one cycle. retired increments once.
- BRANCH at PC=5, branch_taken=1, target=0x3E -> instruction_addr 5->6->0x3E. Repeat with branch_taken=0 -> stays at 6. PC=63 NOP -> wraps to 0.
- FETCH with mem_ack never asserted, WAIT_MAX=7 -> fault=1 and halted=1 after 7 waiting cycles. retired unchanged, all strobes 0 thereafter.
- HALT opcode 0xF -> halted=1, retired+1, no further strobes for 50 cycles. With retired preset to 0xFFFF (CNT_W=16), retired stays 0xFFFF.
